// File: rtl/util_cpack2_timestamp.sv
// Packed-ADC FIFO that inserts a 64-bit timestamp header word ahead of every block of data words.
// Optional macro CPACK2_TIMESTAMP_DROP_FLAG_EN puts a sticky "words dropped" flag in header bit 63.
module util_cpack2_timestamp #(
  parameter int unsigned NUM_OF_CHANNELS     = 4,
  parameter int unsigned SAMPLES_PER_CHANNEL = 1,
  parameter int unsigned SAMPLE_DATA_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH          = 16
) (
  input  logic                                                          adc_clk,
  input  logic                                                          reset,
  input  logic                                                          xfer_req,
  input  logic [63:0]                                                   timestamp,
  input  logic [31:0]                                                   timestamp_every,
  input  logic                                                          s_axis_valid,
  input  logic [NUM_OF_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_DATA_WIDTH-1:0] s_axis_data,
  output logic                                                          m_axis_valid,
  input  logic                                                          m_axis_ready,
  output logic [NUM_OF_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_DATA_WIDTH-1:0] m_axis_data,
  output logic                                                          overflow
);

  localparam int unsigned W  = NUM_OF_CHANNELS * SAMPLES_PER_CHANNEL * SAMPLE_DATA_WIDTH;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   blk_cnt;
  logic [31:0]   every_q;
  logic          valid_q;
  logic          ovf_q;

  logic [31:0]   eff_every_c;
  logic [31:0]   blk_inc_c;
  logic [31:0]   blk_cnt_nxt_c;
  logic [CW-1:0] free_c;
  logic [CW-1:0] wr_num_c;
  logic [CW-1:0] count_nxt_c;
  logic [AW-1:0] wr_ptr_p1_c;
  logic [AW-1:0] wr_ptr_nxt_c;
  logic [AW-1:0] rd_ptr_nxt_c;
  logic          hdr_due_c;
  logic          space_ok_c;
  logic          wr_c;
  logic          drop_c;
  logic          pop_c;
  logic [W-1:0]  hdr_word_c;

  // Block length is re-sampled only while the counter sits at 0 (wrap, drop or idle).
  always_comb begin
    eff_every_c   = (blk_cnt == 32'd0) ? timestamp_every : every_q;
    hdr_due_c     = (eff_every_c != 32'd0) && (blk_cnt == 32'd0);
    free_c        = CW'(FIFO_DEPTH) - count;
    space_ok_c    = hdr_due_c ? (free_c >= CW'(2)) : (free_c != CW'(0));
    pop_c         = valid_q && m_axis_ready;
    wr_c          = xfer_req && s_axis_valid && space_ok_c;
    drop_c        = xfer_req && s_axis_valid && !space_ok_c;
    blk_inc_c     = blk_cnt + 32'd1;
    blk_cnt_nxt_c = blk_cnt;
    if (!xfer_req || drop_c || (eff_every_c == 32'd0)) begin
      blk_cnt_nxt_c = 32'd0;
    end else if (wr_c) begin
      blk_cnt_nxt_c = (blk_inc_c >= eff_every_c) ? 32'd0 : blk_inc_c;
    end
    wr_num_c      = wr_c ? (hdr_due_c ? CW'(2) : CW'(1)) : CW'(0);
    count_nxt_c   = count + wr_num_c - (pop_c ? CW'(1) : CW'(0));
    wr_ptr_p1_c   = wr_ptr + AW'(1);
    wr_ptr_nxt_c  = wr_ptr + AW'(wr_num_c);
    rd_ptr_nxt_c  = pop_c ? (rd_ptr + AW'(1)) : rd_ptr;
  end

  // Control state; space checks above use the occupancy before this cycle's pop.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      blk_cnt <= '0;
      every_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt_c;
      rd_ptr  <= rd_ptr_nxt_c;
      count   <= count_nxt_c;
      blk_cnt <= blk_cnt_nxt_c;
      every_q <= eff_every_c;
      valid_q <= (count_nxt_c != CW'(0));
      ovf_q   <= drop_c;
    end
  end

  // Storage; a header cycle writes two consecutive entries.
  always_ff @(posedge adc_clk) begin
    if (!reset && wr_c) begin
      if (hdr_due_c) begin
        mem[wr_ptr]      <= hdr_word_c;
        mem[wr_ptr_p1_c] <= s_axis_data;
      end else begin
        mem[wr_ptr] <= s_axis_data;
      end
    end
  end

`ifdef CPACK2_TIMESTAMP_DROP_FLAG_EN
  logic drop_flag;
  logic ts_msb_unused;

  assign ts_msb_unused = timestamp[63];

  // Sticky until the next header reports it.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      drop_flag <= 1'b0;
    end else if (drop_c) begin
      drop_flag <= 1'b1;
    end else if (wr_c && hdr_due_c) begin
      drop_flag <= 1'b0;
    end
  end

  assign hdr_word_c = W'({drop_flag, timestamp[62:0]});
`else
  assign hdr_word_c = W'(timestamp);
`endif

  assign m_axis_valid = valid_q;
  assign m_axis_data  = valid_q ? mem[rd_ptr] : '0;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_util_cpack2_timestamp.sv
// Self-checking bench for util_cpack2_timestamp: scoreboard model plus targeted block/drop/reset sequences.
module tb_util_cpack2_timestamp;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 64;

  logic          adc_clk = 1'b0;
  logic          reset;
  logic          xfer_req;
  logic [63:0]   timestamp;
  logic [31:0]   timestamp_every;
  logic          s_axis_valid;
  logic [W-1:0]  s_axis_data;
  logic          m_axis_valid;
  logic          m_axis_ready;
  logic [W-1:0]  m_axis_data;
  logic          overflow;

  always #5 adc_clk = ~adc_clk;

  util_cpack2_timestamp #(
    .NUM_OF_CHANNELS    (4),
    .SAMPLES_PER_CHANNEL(1),
    .SAMPLE_DATA_WIDTH  (16),
    .FIFO_DEPTH         (DEPTH)
  ) dut (
    .adc_clk        (adc_clk),
    .reset          (reset),
    .xfer_req       (xfer_req),
    .timestamp      (timestamp),
    .timestamp_every(timestamp_every),
    .s_axis_valid   (s_axis_valid),
    .s_axis_data    (s_axis_data),
    .m_axis_valid   (m_axis_valid),
    .m_axis_ready   (m_axis_ready),
    .m_axis_data    (m_axis_data),
    .overflow       (overflow)
  );

  typedef struct {
    logic         v;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         tbl [5];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] got_q [$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           ovf_seen = 0;
  logic [31:0]  m_cnt;
  logic         m_flag;
  logic         m_ovf;
  logic [63:0]  ts;
  logic [31:0]  n_every;
  logic [63:0]  ts_mark;
  logic         flag_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] hdr_of(input logic [63:0] t);
`ifdef CPACK2_TIMESTAMP_DROP_FLAG_EN
    return {m_flag, t[62:0]};
`else
    return t;
`endif
  endfunction

  function automatic logic [W-1:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return {W{1'bx}};
  endfunction

  // One clock: check outputs against the model, then advance the model with this cycle's inputs.
  task automatic step(input logic xf, input logic v, input logic [W-1:0] d, input logic rdy);
    int   occ;
    logic due;
    logic ovf_nxt;
    xfer_req        = xf;
    s_axis_valid    = v;
    s_axis_data     = d;
    m_axis_ready    = rdy;
    timestamp       = ts;
    timestamp_every = n_every;
    #1;
    chk("m_axis_valid", 64'(m_axis_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("m_axis_data", m_axis_data, exp_q[0]);
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (overflow) ovf_seen++;
    if (m_axis_valid && rdy) got_q.push_back(m_axis_data);
    occ     = exp_q.size();
    ovf_nxt = 1'b0;
    if (!xf) begin
      m_cnt = 32'd0;
    end else if (v) begin
      due = (n_every != 32'd0) && (m_cnt == 32'd0);
      if (int'(DEPTH) - occ >= (due ? 2 : 1)) begin
        if (due) begin
          exp_q.push_back(hdr_of(ts));
          m_flag = 1'b0;
        end
        exp_q.push_back(d);
        m_cnt = ((n_every == 32'd0) || (m_cnt + 32'd1 == n_every)) ? 32'd0 : m_cnt + 32'd1;
      end else begin
        ovf_nxt = 1'b1;
        m_cnt   = 32'd0;
        m_flag  = 1'b1;
      end
    end
    if (occ != 0 && rdy) void'(exp_q.pop_front());
    @(posedge adc_clk);
    #1;
    m_ovf = ovf_nxt;
    ts    = ts + 64'd1;
  endtask

  task automatic drain(input int k);
    repeat (k) step(1'b1, 1'b0, '0, 1'b1);
  endtask

  task automatic reset_dut();
    reset        = 1'b1;
    xfer_req     = 1'b0;
    s_axis_valid = 1'b0;
    m_axis_ready = 1'b0;
    @(posedge adc_clk);
    #1;
    chk("rst_valid", 64'(m_axis_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_data", m_axis_data, 64'd0);
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
    m_cnt    = 32'd0;
    m_flag   = 1'b0;
    m_ovf    = 1'b0;
    ovf_seen = 0;
  endtask

  initial begin
    reset = 1'b1; xfer_req = 1'b0; s_axis_valid = 1'b0; s_axis_data = '0;
    m_axis_ready = 1'b0; timestamp = '0; timestamp_every = '0;
    ts = 64'd50; n_every = 32'd0; m_cnt = '0; m_flag = 1'b0; m_ovf = 1'b0;
`ifdef CPACK2_TIMESTAMP_DROP_FLAG_EN
    flag_exp = 1'b1;
`else
    flag_exp = 1'b0;
`endif
    reset_dut();

    // No headers: five words pass through unchanged
    tbl[0] = '{1'b1, 64'h0000_0000_0000_00A0, 64'h0000_0000_0000_00A0};
    tbl[1] = '{1'b1, 64'hFFFF_0000_1234_5678, 64'hFFFF_0000_1234_5678};
    tbl[2] = '{1'b1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
    tbl[3] = '{1'b1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    tbl[4] = '{1'b1, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D};
    for (int i = 0; i < 5; i++) step(1'b1, tbl[i].v, tbl[i].data, 1'b1);
    drain(4);
    chk("n0_count", 64'(got_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) chk("n0_word", got_at(i), tbl[i].exp);
    chk("n0_overflow_seen", 64'(ovf_seen), 64'd0);

    // N=3, valid every other cycle, first word at timestamp 100
    n_every = 32'd3; got_q.delete(); ovf_seen = 0; ts = 64'd100;
    step(1'b1, 1'b1, 64'hD0, 1'b1);
    step(1'b1, 1'b0, '0,     1'b1);
    step(1'b1, 1'b1, 64'hD1, 1'b1);
    step(1'b1, 1'b0, '0,     1'b1);
    step(1'b1, 1'b1, 64'hD2, 1'b1);
    step(1'b1, 1'b0, '0,     1'b1);
    step(1'b1, 1'b1, 64'hD3, 1'b1);
    drain(6);
    chk("n3_count", 64'(got_q.size()), 64'd6);
    chk("n3_hdr0", got_at(0), 64'd100);
    chk("n3_d0", got_at(1), 64'hD0);
    chk("n3_d2", got_at(3), 64'hD2);
    chk("n3_hdr1", got_at(4), 64'd106);
    chk("n3_d3", got_at(5), 64'hD3);

    // Fill with ready low, drops pulse overflow, recovery header carries drop flag
    reset_dut();
    n_every = 32'd2;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 64'hE0 + 64'(i), 1'b0);
    drain(5);
    chk("fill_overflow_seen", 64'(ovf_seen), 64'd4);
    ts_mark = ts;
    step(1'b1, 1'b1, 64'hE6, 1'b1);
    drain(4);
    chk("fill_count", 64'(got_q.size()), 64'd5);
    chk("fill_d1", got_at(2), 64'hE1);
    chk("fill_hdr_flag", 64'(got_at(3) >> 63), 64'(flag_exp));
    chk("fill_hdr_ts", 64'(got_at(3) & 64'h7FFF_FFFF_FFFF_FFFF), ts_mark);
    chk("fill_d6", got_at(4), 64'hE6);

    // One free entry at a header-due word, including pop in the same cycle
    reset_dut();
    n_every = 32'd2;
    step(1'b1, 1'b1, 64'hF0, 1'b0);
    step(1'b1, 1'b1, 64'hF1, 1'b0);
    step(1'b1, 1'b1, 64'hF2, 1'b0);
    step(1'b1, 1'b1, 64'hF3, 1'b1);
    step(1'b1, 1'b1, 64'hF4, 1'b0);
    drain(6);
    chk("tight_overflow_seen", 64'(ovf_seen), 64'd2);
    chk("tight_count", 64'(got_q.size()), 64'd5);
    chk("tight_d4", got_at(4), 64'hF4);

    // xfer_req low mid-block
    reset_dut();
    n_every = 32'd4;
    step(1'b1, 1'b1, 64'h10, 1'b1);
    step(1'b1, 1'b1, 64'h11, 1'b1);
    step(1'b0, 1'b1, 64'h12, 1'b1);
    step(1'b0, 1'b1, 64'h13, 1'b1);
    ts_mark = ts;
    step(1'b1, 1'b1, 64'h14, 1'b1);
    drain(5);
    chk("xfer_count", 64'(got_q.size()), 64'd5);
    chk("xfer_d1", got_at(2), 64'h11);
    chk("xfer_hdr", got_at(3), ts_mark);
    chk("xfer_d", got_at(4), 64'h14);
    chk("xfer_overflow_seen", 64'(ovf_seen), 64'd0);

    // Reset with three words buffered
    reset_dut();
    n_every = 32'd2;
    step(1'b1, 1'b1, 64'h20, 1'b0);
    step(1'b1, 1'b1, 64'h21, 1'b0);
    chk("prerst_valid", 64'(m_axis_valid), 64'd1);
    reset_dut();
    ts_mark = ts;
    step(1'b1, 1'b1, 64'h22, 1'b1);
    drain(3);
    chk("rst_count", 64'(got_q.size()), 64'd2);
    chk("rst_hdr", got_at(0), ts_mark);
    chk("rst_d", got_at(1), 64'h22);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
